// File: rtl/arbiter_rr_mem_request_pkg.sv
// Shared types and default sizing for the CU-bundle memory-request arbiter.
// The defaults follow the bundle count and the global address/data widths.
package arbiter_rr_mem_request_pkg;

   localparam int CU_BUNDLE_COUNT        = 4;
   localparam int GLOBAL_ADDR_WIDTH_BITS = 64;
   localparam int GLOBAL_DATA_WIDTH_BITS = 32;
   localparam int DEFAULT_MAX_BURST      = 4;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_GRANT = 2'd1,
      ARB_LOCK  = 2'd2
   } arb_state_t;

   typedef enum logic {
      ARB_MODE_RR    = 1'b0,
      ARB_MODE_FIXED = 1'b1
   } arb_mode_t;

   // A tag is at least one bit wide, even with a single channel.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/arbiter_rr_pick_n.sv
// Rotating find-first-set: picks the first set mask bit at or above base,
// wrapping to index 0. A base of 0 gives plain lowest-index priority.
module arbiter_rr_pick_n
   import arbiter_rr_mem_request_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = id_width(N)
) (
   input  logic [N-1:0]  mask,
   input  logic [IW-1:0] base,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] index,
   output logic          found
);

   // The first pass covers base..N-1 and the second covers 0..base-1.
   always_comb begin
      onehot = '0;
      index  = '0;
      found  = 1'b0;
      for (int c = 0; c < N; c++) begin
         if (!found && mask[c] && (IW'(c) >= base)) begin
            found     = 1'b1;
            onehot[c] = 1'b1;
            index     = IW'(c);
         end
      end
      for (int c = 0; c < N; c++) begin
         if (!found && mask[c] && (IW'(c) < base)) begin
            found     = 1'b1;
            onehot[c] = 1'b1;
            index     = IW'(c);
         end
      end
   end

endmodule

// File: rtl/arbiter_rr_mem_request.sv
// N-channel memory-request arbiter with round-robin/fixed priority and optional
// burst-lock. It feeds one registered output stage toward the cache front end.
module arbiter_rr_mem_request
   import arbiter_rr_mem_request_pkg::*;
#(
   parameter int NUM_CHANNELS = CU_BUNDLE_COUNT,
   parameter int ADDR_WIDTH   = GLOBAL_ADDR_WIDTH_BITS,
   parameter int DATA_WIDTH   = GLOBAL_DATA_WIDTH_BITS,
   parameter int MAX_BURST    = DEFAULT_MAX_BURST,
   parameter int ID_WIDTH     = id_width(NUM_CHANNELS)
) (
   input  logic                             ap_clk,
   input  logic                             ap_rst_n,
   input  logic                             cfg_mode_in,
   input  logic                             cfg_lock_en_in,
   input  logic [NUM_CHANNELS-1:0]          req_valid_in,
   input  logic [NUM_CHANNELS-1:0]          req_last_in,
   input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] req_addr_in,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] req_data_in,
   output logic [NUM_CHANNELS-1:0]          req_ready_out,
   output logic                             out_valid_out,
   input  logic                             out_ready_in,
   output logic [ADDR_WIDTH-1:0]            out_addr_out,
   output logic [DATA_WIDTH-1:0]            out_data_out,
   output logic [ID_WIDTH-1:0]              out_id_out,
   output logic                             out_last_out,
   output logic                             busy_out
);

   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [ID_WIDTH-1:0] LAST_IDX    = ID_WIDTH'(NUM_CHANNELS - 1);
   localparam logic [CW-1:0]       BURST_LIMIT = CW'(MAX_BURST);

   arb_state_t state, state_next;
   arb_mode_t  mode_q, mode_eff;
   logic       lock_en_q, lock_en_eff;

   logic [ID_WIDTH-1:0]     rr_ptr, rr_ptr_next;
   logic [ID_WIDTH-1:0]     lock_ch, lock_ch_next;
   logic [CW-1:0]           burst_cnt, burst_cnt_next;
   logic [ID_WIDTH-1:0]     pick_base, pick_idx, grant_idx;
   logic [NUM_CHANNELS-1:0] pick_onehot, grant;
   logic                    pick_found, grant_any, grant_last;
   logic                    stage_free, accept, out_valid_next;

   function automatic logic [ID_WIDTH-1:0] wrap_inc(input logic [ID_WIDTH-1:0] idx);
      return (idx == LAST_IDX) ? '0 : idx + ID_WIDTH'(1);
   endfunction

   // In IDLE the live cfg inputs apply, so the very first beat already uses them.
   assign mode_eff    = (state == ARB_IDLE) ? arb_mode_t'(cfg_mode_in) : mode_q;
   assign lock_en_eff = (state == ARB_IDLE) ? cfg_lock_en_in : lock_en_q;
   assign pick_base   = (mode_eff == ARB_MODE_FIXED) ? '0 : rr_ptr;

   arbiter_rr_pick_n #(
      .N  (NUM_CHANNELS),
      .IW (ID_WIDTH)
   ) u_pick (
      .mask   (req_valid_in),
      .base   (pick_base),
      .onehot (pick_onehot),
      .index  (pick_idx),
      .found  (pick_found)
   );

   always_comb begin
      grant     = '0;
      grant_idx = pick_idx;
      grant_any = 1'b0;
      if (state == ARB_LOCK) begin
         grant_idx = lock_ch;
         if (req_valid_in[lock_ch]) begin
            grant[lock_ch] = 1'b1;
            grant_any      = 1'b1;
         end
      end else begin
         grant     = pick_onehot;
         grant_any = pick_found;
      end
   end

   assign stage_free     = !out_valid_out || out_ready_in;
   assign accept         = stage_free && grant_any;
   assign req_ready_out  = accept ? grant : '0;
   assign grant_last     = req_last_in[grant_idx];
   assign out_valid_next = accept || (out_valid_out && !out_ready_in);

   always_comb begin
      state_next     = state;
      rr_ptr_next    = rr_ptr;
      lock_ch_next   = lock_ch;
      burst_cnt_next = burst_cnt;
      case (state)
         ARB_IDLE, ARB_GRANT: begin
            if (accept) begin
               rr_ptr_next = wrap_inc(grant_idx);
               // With MAX_BURST of 1 the first beat already exhausts the burst.
               if (lock_en_eff && !grant_last && (MAX_BURST > 1)) begin
                  state_next     = ARB_LOCK;
                  lock_ch_next   = grant_idx;
                  burst_cnt_next = CW'(1);
               end else begin
                  state_next = ARB_GRANT;
               end
            end else if (|req_valid_in) begin
               state_next = ARB_GRANT;
            end else if (!out_valid_next) begin
               state_next = ARB_IDLE;
            end
         end
         ARB_LOCK: begin
            if (!req_valid_in[lock_ch]) begin
               state_next     = ARB_GRANT;
               rr_ptr_next    = wrap_inc(lock_ch);
               burst_cnt_next = '0;
            end else if (accept) begin
               if (grant_last || ((burst_cnt + CW'(1)) == BURST_LIMIT)) begin
                  state_next     = ARB_GRANT;
                  rr_ptr_next    = wrap_inc(lock_ch);
                  burst_cnt_next = '0;
               end else begin
                  burst_cnt_next = burst_cnt + CW'(1);
               end
            end
         end
         default: state_next = ARB_IDLE;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         state         <= ARB_IDLE;
         mode_q        <= ARB_MODE_RR;
         lock_en_q     <= 1'b0;
         rr_ptr        <= '0;
         lock_ch       <= '0;
         burst_cnt     <= '0;
         out_valid_out <= 1'b0;
         out_addr_out  <= '0;
         out_data_out  <= '0;
         out_id_out    <= '0;
         out_last_out  <= 1'b0;
         busy_out      <= 1'b0;
      end else begin
         state         <= state_next;
         rr_ptr        <= rr_ptr_next;
         lock_ch       <= lock_ch_next;
         burst_cnt     <= burst_cnt_next;
         out_valid_out <= out_valid_next;
         busy_out      <= (state_next != ARB_IDLE) || out_valid_next;
         if (state == ARB_IDLE) begin
            mode_q    <= mode_eff;
            lock_en_q <= lock_en_eff;
         end
         if (accept) begin
            out_addr_out <= req_addr_in[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
            out_data_out <= req_data_in[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            out_id_out   <= grant_idx;
            out_last_out <= grant_last;
         end
      end
   end

endmodule

// File: tb/tb_arbiter_rr_mem_request.sv
// Directed bench for the memory-request arbiter: a vector table for arbitration
// order plus hand-written burst-lock, forced-release, backpressure and reset sequences.
module tb_arbiter_rr_mem_request;

   localparam int NCH = 4;
   localparam int AW  = 64;
   localparam int DW  = 32;

   logic              ap_clk;
   logic              ap_rst_n;
   logic              cfg_mode_in;
   logic              cfg_lock_en_in;
   logic [NCH-1:0]    req_valid_in;
   logic [NCH-1:0]    req_last_in;
   logic [NCH*AW-1:0] req_addr_in;
   logic [NCH*DW-1:0] req_data_in;
   logic [NCH-1:0]    req_ready_out;
   logic              out_valid_out;
   logic              out_ready_in;
   logic [AW-1:0]     out_addr_out;
   logic [DW-1:0]     out_data_out;
   logic [1:0]        out_id_out;
   logic              out_last_out;
   logic              busy_out;

   typedef struct {
      logic [3:0] valid;
      logic [3:0] last;
      logic       mode;
      logic       lock;
      logic       oready;
      logic [3:0] exp_ready;
      logic       exp_valid;
      logic [1:0] exp_id;
      logic       exp_busy;
   } vec_t;

   vec_t       vecs[17];
   logic [1:0] fr_ids[10];
   int         checks;
   int         passes;

   arbiter_rr_mem_request #(
      .NUM_CHANNELS (NCH),
      .ADDR_WIDTH   (AW),
      .DATA_WIDTH   (DW),
      .MAX_BURST    (4),
      .ID_WIDTH     (2)
   ) dut (
      .ap_clk         (ap_clk),
      .ap_rst_n       (ap_rst_n),
      .cfg_mode_in    (cfg_mode_in),
      .cfg_lock_en_in (cfg_lock_en_in),
      .req_valid_in   (req_valid_in),
      .req_last_in    (req_last_in),
      .req_addr_in    (req_addr_in),
      .req_data_in    (req_data_in),
      .req_ready_out  (req_ready_out),
      .out_valid_out  (out_valid_out),
      .out_ready_in   (out_ready_in),
      .out_addr_out   (out_addr_out),
      .out_data_out   (out_data_out),
      .out_id_out     (out_id_out),
      .out_last_out   (out_last_out),
      .busy_out       (busy_out)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   function automatic logic [63:0] addr_of(input logic [1:0] ch);
      return 64'hA5A5_0000_0000_0000 + 64'(ch) * 64'h1111;
   endfunction

   function automatic logic [31:0] data_of(input logic [1:0] ch);
      return 32'hC0DE_0000 + 32'(ch);
   endfunction

   task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] last,
                                input logic mode, input logic lock, input logic oready);
      @(negedge ap_clk);
      req_valid_in   = valid;
      req_last_in    = last;
      cfg_mode_in    = mode;
      cfg_lock_en_in = lock;
      out_ready_in   = oready;
      #1;
   endtask

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected)
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      else
         passes++;
   endtask

   task automatic checkBeat(input string tag, input logic [1:0] id);
      checkOutput({tag, " out_valid"}, 64'(out_valid_out), 64'(1));
      checkOutput({tag, " out_id"}, 64'(out_id_out), 64'(id));
      checkOutput({tag, " out_addr"}, out_addr_out, addr_of(id));
      checkOutput({tag, " out_data"}, 64'(out_data_out), 64'(data_of(id)));
   endtask

   task automatic doReset();
      @(negedge ap_clk);
      ap_rst_n     = 1'b0;
      req_valid_in = '0;
      req_last_in  = '0;
      tick();
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
   endtask

   initial begin
      checks         = 0;
      passes         = 0;
      ap_rst_n       = 1'b0;
      cfg_mode_in    = 1'b0;
      cfg_lock_en_in = 1'b0;
      req_valid_in   = '0;
      req_last_in    = '0;
      out_ready_in   = 1'b1;
      for (int c = 0; c < NCH; c++) begin
         req_addr_in[c*AW +: AW] = addr_of(2'(c));
         req_data_in[c*DW +: DW] = data_of(2'(c));
      end

      // Arbitration order from reset: rr sweep, cfg change ignored, fixed prio, wrap.
      vecs[0]  = '{4'b1111, 4'b1111, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
      vecs[1]  = '{4'b1111, 4'b1111, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
      vecs[2]  = '{4'b1111, 4'b1111, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
      vecs[3]  = '{4'b1111, 4'b1111, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
      vecs[4]  = '{4'b1111, 4'b1111, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
      vecs[5]  = '{4'b1010, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
      vecs[6]  = '{4'b1010, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
      vecs[7]  = '{4'b0000, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
      vecs[8]  = '{4'b1010, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
      vecs[9]  = '{4'b1010, 4'b1111, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
      vecs[10] = '{4'b1010, 4'b1111, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
      vecs[11] = '{4'b1000, 4'b1111, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
      vecs[12] = '{4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
      vecs[13] = '{4'b0101, 4'b1111, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
      vecs[14] = '{4'b0101, 4'b1111, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
      vecs[15] = '{4'b0101, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1};
      vecs[16] = '{4'b0101, 4'b1111, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};

      fr_ids = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd1, 2'd1, 2'd1, 2'd1, 2'd3};

      repeat (2) @(posedge ap_clk);
      #1;
      checkOutput("reset out_valid", 64'(out_valid_out), 64'(0));
      checkOutput("reset out_addr", out_addr_out, 64'(0));
      checkOutput("reset out_id", 64'(out_id_out), 64'(0));
      checkOutput("reset busy", 64'(busy_out), 64'(0));
      checkOutput("reset req_ready", 64'(req_ready_out), 64'(0));
      @(negedge ap_clk);
      ap_rst_n = 1'b1;

      for (int i = 0; i < 17; i++) begin
         applyStimulus(vecs[i].valid, vecs[i].last, vecs[i].mode, vecs[i].lock, vecs[i].oready);
         checkOutput($sformatf("vec%0d req_ready", i), 64'(req_ready_out), 64'(vecs[i].exp_ready));
         tick();
         checkOutput($sformatf("vec%0d out_valid", i), 64'(out_valid_out), 64'(vecs[i].exp_valid));
         checkOutput($sformatf("vec%0d busy", i), 64'(busy_out), 64'(vecs[i].exp_busy));
         if (vecs[i].exp_valid)
            checkBeat($sformatf("vec%0d", i), vecs[i].exp_id);
      end

      // Burst-lock: channel 2 keeps the grant for three beats while channel 0 waits.
      doReset();
      applyStimulus(4'b0100, 4'b0000, 1'b0, 1'b1, 1'b1);
      checkOutput("lock b1 req_ready", 64'(req_ready_out), 64'(4'b0100));
      tick();
      checkBeat("lock b1", 2'd2);
      applyStimulus(4'b0101, 4'b0001, 1'b0, 1'b1, 1'b1);
      checkOutput("lock b2 req_ready", 64'(req_ready_out), 64'(4'b0100));
      tick();
      checkBeat("lock b2", 2'd2);
      applyStimulus(4'b0101, 4'b0101, 1'b0, 1'b1, 1'b1);
      checkOutput("lock b3 req_ready", 64'(req_ready_out), 64'(4'b0100));
      tick();
      checkBeat("lock b3", 2'd2);
      checkOutput("lock b3 out_last", 64'(out_last_out), 64'(1));
      applyStimulus(4'b0001, 4'b0101, 1'b0, 1'b1, 1'b1);
      checkOutput("lock after req_ready", 64'(req_ready_out), 64'(4'b0001));
      tick();
      checkBeat("lock after", 2'd0);

      // Forced release after MAX_BURST beats lets channel 3 in between bursts.
      doReset();
      for (int b = 0; b < 10; b++) begin
         applyStimulus(4'b1010, 4'b1000, 1'b0, 1'b1, 1'b1);
         if (b >= 1 && b <= 3)
            checkOutput($sformatf("fr b%0d ch3 ready", b), 64'(req_ready_out[3]), 64'(0));
         tick();
         checkBeat($sformatf("fr b%0d", b), fr_ids[b]);
      end

      // Backpressure: the held beat stays put, then pops while the next one enters.
      doReset();
      applyStimulus(4'b0011, 4'b0011, 1'b0, 1'b0, 1'b1);
      tick();
      checkBeat("bp first", 2'd0);
      for (int k = 0; k < 5; k++) begin
         applyStimulus(4'b0011, 4'b0011, 1'b0, 1'b0, 1'b0);
         checkOutput($sformatf("bp hold%0d req_ready", k), 64'(req_ready_out), 64'(0));
         tick();
         checkBeat($sformatf("bp hold%0d", k), 2'd0);
      end
      applyStimulus(4'b0011, 4'b0011, 1'b0, 1'b0, 1'b1);
      checkOutput("bp release req_ready", 64'(req_ready_out), 64'(4'b0010));
      tick();
      checkBeat("bp release", 2'd1);

      // Reset in the middle of a channel-1 lock clears the pointer and the held beat.
      doReset();
      applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b1, 1'b1);
      tick();
      checkBeat("rst lock b1", 2'd1);
      applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b1, 1'b1);
      tick();
      checkBeat("rst lock b2", 2'd1);
      @(negedge ap_clk);
      ap_rst_n     = 1'b0;
      req_valid_in = '0;
      tick();
      checkOutput("rst mid out_valid", 64'(out_valid_out), 64'(0));
      checkOutput("rst mid busy", 64'(busy_out), 64'(0));
      checkOutput("rst mid out_id", 64'(out_id_out), 64'(0));
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      applyStimulus(4'b0101, 4'b0101, 1'b0, 1'b0, 1'b1);
      checkOutput("rst after req_ready", 64'(req_ready_out), 64'(4'b0001));
      tick();
      checkBeat("rst after", 2'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/arbiter_rr_mem_request.md
Name: arbiter_rr_mem_request

Overview:
- N-channel memory-request arbiter that merges per-bundle engine requests (address + data) into one registered stream toward the cache front end.
- Parametrised in channel count, address width and data width.
- Adds run-time mode selection (round-robin or fixed priority) and optional burst-lock, so a channel can hold the grant for consecutive beats.
- Sits between the CU bundles and the cache/AXI request path.

Parameters:
- NUM_CHANNELS, 4 (CU_BUNDLE_COUNT), number of requesters, 2..16.
- ADDR_WIDTH, 64 (GLOBAL_ADDR_WIDTH_BITS), request address width.
- DATA_WIDTH, 32 (GLOBAL_DATA_WIDTH_BITS), request data width.
- MAX_BURST, 4, maximum consecutive beats a locked channel keeps the grant, 1..256.
- ID_WIDTH, $clog2(NUM_CHANNELS) (minimum 1), width of the source-channel tag.

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  synchronous active-low reset.
- cfg_mode_in  in  1  0 = round-robin, 1 = fixed priority (channel 0 highest); sampled only in ARB_IDLE.
- cfg_lock_en_in  in  1  1 = enable burst-lock; sampled only in ARB_IDLE.
- req_valid_in  in  NUM_CHANNELS  per-channel request valid.
- req_last_in  in  NUM_CHANNELS  per-channel last beat of a burst.
- req_addr_in  in  NUM_CHANNELS*ADDR_WIDTH  packed addresses, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data_in  in  NUM_CHANNELS*DATA_WIDTH  packed data, same packing.
- req_ready_out  out  NUM_CHANNELS  one-hot or zero; accept signal per channel.
- out_valid_out  out  1  output request valid.
- out_ready_in  in  1  downstream ready.
- out_addr_out  out  ADDR_WIDTH  granted address.
- out_data_out  out  DATA_WIDTH  granted data.
- out_id_out  out  ID_WIDTH  source channel index.
- out_last_out  out  1  forwarded last flag.
- busy_out  out  1  high when the FSM is not in ARB_IDLE or out_valid_out is high.

Behaviour:
- Reset (ap_rst_n=0 at a rising edge): out_valid_out=0, out_addr_out/out_data_out/out_id_out/out_last_out=0, req_ready_out=0, busy_out=0, rr pointer=0, burst counter=0, FSM=ARB_IDLE. Reset mid-burst discards the held output beat with no handshake.
- Output stage: one register. Accept a beat when `stage_free = !out_valid_out || out_ready_in`. req_ready_out[g] = stage_free && grant[g] && req_valid_in[g]; all other bits are 0.
- Latency: an accepted beat appears on the output at the next edge (1 cycle). Full throughput, 1 beat/cycle, while out_ready_in=1.
- Output hold: while out_valid_out=1 and out_ready_in=0, all out_* fields hold stable.
- Grant selection (combinational, FSM in ARB_IDLE or ARB_GRANT):
  - Round-robin: first valid channel searching from the rr pointer upward, with wrap-around.
  - Fixed priority: lowest-index valid channel.
  - On each accepted beat outside lock, rr pointer <= (granted index + 1) mod NUM_CHANNELS.
- FSM states:
  - ARB_IDLE: latch cfg_mode/cfg_lock_en. Any valid -> ARB_GRANT the same cycle (grant is combinational, so the first beat can be accepted in IDLE).
  - ARB_GRANT: each accept re-arbitrates. If lock_en and the accepted beat has last=0 -> ARB_LOCK, latching the granted channel, burst counter=1. If no valid and the stage is empty -> ARB_IDLE.
  - ARB_LOCK: only the latched channel is granted. Each accept increments the burst counter. Leave to ARB_GRANT (pointer = latched+1) when:
    - the accepted beat has last=1, or
    - the counter reaches MAX_BURST (forced release), or
    - the latched channel deasserts valid (release the same cycle, no accept).
  - Other channels' valids are ignored in ARB_LOCK.
- Starvation bound: in round-robin, a continuously valid channel is served within (NUM_CHANNELS-1)*MAX_BURST+1 accepts. Fixed priority gives no such bound; this is documented, not an error.
- Simultaneous events: downstream pop and upstream accept in the same cycle are both allowed (stage_free via out_ready_in). A cfg change outside ARB_IDLE has no effect until the next ARB_IDLE.
- busy_out is registered: it reflects the state after the edge.

Decomposition:
- Shared package (PKG_GLOBALS or a new PKG_ARBITER):
  - arb_state_t enum {ARB_IDLE, ARB_GRANT, ARB_LOCK}.
  - arb_mode_t enum {ARB_MODE_RR, ARB_MODE_FIXED}.
  - Default constants tied to CU_BUNDLE_COUNT and GLOBAL_ADDR/DATA_WIDTH_BITS.
- Sub-module: arbiter_rr_pick_n — combinational find-first-set with base rotation; input mask and base, outputs one-hot plus index. Fixed-priority mode uses it with base=0.

Test Plan:
- Round-robin fairness: NUM_CHANNELS=4, all valid, last=1, out_ready=1, lock off -> out_id sequence 0,1,2,3,0,1,…; one beat per cycle after 1-cycle latency.
- Fixed priority: mode=1, channels 1 and 3 valid continuously -> out_id always 1; channel 3 req_ready stays 0.
- Burst-lock: lock_en=1, channel 2 sends 3 beats (last on beat 3) while channel 0 is valid -> out_id 2,2,2 then 0.
- Forced release: MAX_BURST=4, channel 1 sends 10 beats with last=0, channel 3 valid -> ids 1,1,1,1,3,1,1,1,1,3.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_addr/data/id stable, all req_ready=0. Release -> the held beat pops and the next beat is accepted the same cycle.
- Reset mid-lock: assert ap_rst_n=0 during an ARB_LOCK burst -> next cycle out_valid=0, busy=0, rr pointer=0. The first request after release with channels 0 and 2 valid -> grant 0.
